// File: rtl/mcu_cfg_responder.sv
// MCU-side endpoint of the N64 config command channel.
// Mailbox for one command, aux word terminator and abandon watchdog.
module mcu_cfg_responder #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd10_000_000,
    parameter int          TIMEOUT_WIDTH  = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cfg_pending,
    input  logic [7:0]  cfg_cmd,
    input  logic [31:0] cfg_rdata_0,
    input  logic [31:0] cfg_rdata_1,
    output logic        cfg_done,
    output logic        cfg_error,
    output logic [31:0] cfg_wdata_0,
    output logic [31:0] cfg_wdata_1,
    input  logic        aux_pending,
    input  logic [31:0] aux_rdata,
    output logic [31:0] aux_wdata,
    output logic        aux_irq,
    input  logic [3:0]  mcu_address,
    input  logic        mcu_write,
    input  logic        mcu_read,
    input  logic [31:0] mcu_wdata,
    output logic [31:0] mcu_rdata,
    output logic        mcu_irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_BUSY,
        S_COMPLETE
    } state_t;

    localparam logic [TIMEOUT_WIDTH-1:0] WD_LAST =
        TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 24'd1);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 24'd0);

    state_t state, next;

    logic [TIMEOUT_WIDTH-1:0] wd;
    logic [7:0]  cmd;
    logic [31:0] arg0, arg1, aux_in;
    logic        cmd_valid, done_q, err_q, timeout;
    logic        aux_valid, aux_overrun, busy;
    logic [31:0] rd_mux;

    logic active, wr_status, wr_ack, wr_done, wd_hit, rd_aux;
    logic finish_ok;

    assign active    = (state == S_PENDING) || (state == S_BUSY);
    assign wr_status = mcu_write && (mcu_address == 4'd0);
    assign wr_ack    = mcu_write && (mcu_address == 4'd1) && mcu_wdata[0];
    assign wr_done   = mcu_write && (mcu_address == 4'd6);
    assign rd_aux    = mcu_read && (mcu_address == 4'd7);
    assign wd_hit    = WD_EN && active && (wd == WD_LAST);
    // Command ends normally only while the N64 still holds it; abort wins.
    assign finish_ok = active && cfg_pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:
                if (cfg_pending) next = S_PENDING;
            S_PENDING:
                if (!cfg_pending)          next = S_IDLE;
                else if (wr_done || wd_hit) next = S_COMPLETE;
                else if (wr_ack)           next = S_BUSY;
            S_BUSY:
                if (!cfg_pending)          next = S_IDLE;
                else if (wr_done || wd_hit) next = S_COMPLETE;
            S_COMPLETE:
                if (!cfg_pending) next = S_IDLE;
            default: next = S_IDLE;
        endcase
    end

    always_comb begin
        cfg_done  = done_q;
        cfg_error = done_q && err_q;
        busy      = (state == S_BUSY);
    end

    always_comb begin
        rd_mux = '0;
        case (mcu_address)
            4'd0: rd_mux = {27'd0, timeout, aux_overrun,
                            aux_valid, busy, cmd_valid};
            4'd1: rd_mux = {24'd0, cmd};
            4'd2: rd_mux = arg0;
            4'd3: rd_mux = arg1;
            4'd4: rd_mux = cfg_wdata_0;
            4'd5: rd_mux = cfg_wdata_1;
            4'd7: rd_mux = aux_in;
            4'd8: rd_mux = aux_wdata;
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wd          <= '0;
            cmd         <= '0;
            arg0        <= '0;
            arg1        <= '0;
            cmd_valid   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            timeout     <= 1'b0;
            aux_in      <= '0;
            aux_valid   <= 1'b0;
            aux_overrun <= 1'b0;
            aux_wdata   <= '0;
            aux_irq     <= 1'b0;
            cfg_wdata_0 <= '0;
            cfg_wdata_1 <= '0;
            mcu_rdata   <= '0;
            mcu_irq     <= 1'b0;
        end else begin
            done_q    <= (next == S_COMPLETE) && (state != S_COMPLETE);
            cmd_valid <= (next == S_PENDING) || (next == S_BUSY);
            wd        <= active ? wd + 1'b1 : '0;

            if (state == S_IDLE && cfg_pending) begin
                cmd  <= cfg_cmd;
                arg0 <= cfg_rdata_0;
                arg1 <= cfg_rdata_1;
            end

            if (wr_status && mcu_wdata[4]) timeout <= 1'b0;
            if (finish_ok && wr_done) begin
                err_q <= mcu_wdata[0];
            end else if (finish_ok && wd_hit) begin
                err_q   <= 1'b1;
                timeout <= 1'b1;
            end

            // A read racing a new word returns the old one and keeps valid set.
            if (wr_status && mcu_wdata[3]) aux_overrun <= 1'b0;
            if (aux_pending) begin
                aux_in    <= aux_rdata;
                aux_valid <= 1'b1;
                if (aux_valid && !rd_aux) aux_overrun <= 1'b1;
            end else if (rd_aux) begin
                aux_valid <= 1'b0;
            end

            if (mcu_write && mcu_address == 4'd4) cfg_wdata_0 <= mcu_wdata;
            if (mcu_write && mcu_address == 4'd5) cfg_wdata_1 <= mcu_wdata;
            if (mcu_write && mcu_address == 4'd8) aux_wdata <= mcu_wdata;
            aux_irq <= mcu_write && (mcu_address == 4'd8);

            if (mcu_read) mcu_rdata <= rd_mux;

            mcu_irq <= (cmd_valid && state == S_PENDING)
                     || aux_valid || aux_overrun || timeout;
        end
    end

endmodule

// File: tb/tb_mcu_cfg_responder.sv
// Directed bench for mcu_cfg_responder with a 16-cycle watchdog.
module tb_mcu_cfg_responder;

    logic        clk;
    logic        reset_n;
    logic        cfg_pending;
    logic [7:0]  cfg_cmd;
    logic [31:0] cfg_rdata_0, cfg_rdata_1;
    logic        cfg_done, cfg_error;
    logic [31:0] cfg_wdata_0, cfg_wdata_1;
    logic        aux_pending;
    logic [31:0] aux_rdata, aux_wdata;
    logic        aux_irq;
    logic [3:0]  mcu_address;
    logic        mcu_write, mcu_read;
    logic [31:0] mcu_wdata, mcu_rdata;
    logic        mcu_irq;

    int errors = 0;
    int checks = 0;

    mcu_cfg_responder #(
        .TIMEOUT_CYCLES(24'd16),
        .TIMEOUT_WIDTH (24)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .cfg_pending(cfg_pending),
        .cfg_cmd    (cfg_cmd),
        .cfg_rdata_0(cfg_rdata_0),
        .cfg_rdata_1(cfg_rdata_1),
        .cfg_done   (cfg_done),
        .cfg_error  (cfg_error),
        .cfg_wdata_0(cfg_wdata_0),
        .cfg_wdata_1(cfg_wdata_1),
        .aux_pending(aux_pending),
        .aux_rdata  (aux_rdata),
        .aux_wdata  (aux_wdata),
        .aux_irq    (aux_irq),
        .mcu_address(mcu_address),
        .mcu_write  (mcu_write),
        .mcu_read   (mcu_read),
        .mcu_wdata  (mcu_wdata),
        .mcu_rdata  (mcu_rdata),
        .mcu_irq    (mcu_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mcu_wr(input logic [3:0] a, input logic [31:0] d);
        mcu_address = a;
        mcu_wdata   = d;
        mcu_write   = 1'b1;
        tick();
        mcu_write   = 1'b0;
    endtask

    task automatic mcu_rd(input logic [3:0] a, output logic [31:0] d);
        mcu_address = a;
        mcu_read    = 1'b1;
        tick();
        d           = mcu_rdata;
        mcu_read    = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] o;
        o = {cfg_done, cfg_error, aux_irq, mcu_irq} | cfg_wdata_0
          | cfg_wdata_1 | aux_wdata | mcu_rdata;
        checks++;
        if (o !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", o);
        end
    endtask

    task automatic test_basic();
        logic [31:0] d;
        cfg_cmd     = 8'h43;
        cfg_rdata_0 = 32'h1234_5678;
        cfg_rdata_1 = 32'hDEAD_BEEF;
        cfg_pending = 1'b1;
        tick();
        checks++;
        if (mcu_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_at_capture: got %b want 0", mcu_irq);
        end
        tick();
        checks++;
        if (mcu_irq !== 1'b1) begin
            errors++;
            $display("FAIL irq_after_capture: got %b want 1", mcu_irq);
        end
        mcu_rd(4'd1, d);
        checks++;
        if (d !== 32'h43) begin
            errors++;
            $display("FAIL cmd_read: got %h want 43", d);
        end
        tick();
        checks++;
        if (mcu_rdata !== 32'h43) begin
            errors++;
            $display("FAIL rdata_hold: got %h want 43", mcu_rdata);
        end
        mcu_rd(4'd2, d);
        checks++;
        if (d !== 32'h1234_5678) begin
            errors++;
            $display("FAIL arg0_read: got %h want 12345678", d);
        end
        mcu_rd(4'd3, d);
        checks++;
        if (d !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL arg1_read: got %h want deadbeef", d);
        end
        mcu_wr(4'd1, 32'd1);
        tick();
        checks++;
        if (mcu_irq !== 1'b0) begin
            errors++;
            $display("FAIL irq_after_ack: got %b want 0", mcu_irq);
        end
        mcu_wr(4'd4, 32'hCAFE_0001);
        mcu_wr(4'd6, 32'd0);
        checks++;
        if ({cfg_done, cfg_error} !== 2'b10) begin
            errors++;
            $display("FAIL basic_done: got %b want 10",
                     {cfg_done, cfg_error});
        end
        checks++;
        if (cfg_wdata_0 !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL rsp0: got %h want cafe0001", cfg_wdata_0);
        end
    endtask

    task automatic test_held();
        logic [31:0] d;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({cfg_done, mcu_irq} !== 2'b00) begin
                errors++;
                $display("FAIL held_%0d: got done,irq=%b want 00",
                         i, {cfg_done, mcu_irq});
            end
        end
        cfg_pending = 1'b0;
        tick();
        mcu_rd(4'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL held_status: got %h want 0", d);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        int found;
        logic e;
        found = 0;
        e = 1'b0;
        cfg_cmd = 8'h07;
        cfg_pending = 1'b1;
        tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (cfg_done === 1'b1 && found == 0) begin
                found = k;
                e = cfg_error;
            end
        end
        checks++;
        if (found != 16 || e !== 1'b1) begin
            errors++;
            $display("FAIL timeout_done: got cycle %0d err %b want 16 1",
                     found, e);
        end
        mcu_rd(4'd0, d);
        checks++;
        if (d !== 32'h10 || mcu_irq !== 1'b1) begin
            errors++;
            $display("FAIL timeout_status: got %h irq %b want 10 1",
                     d, mcu_irq);
        end
        cfg_pending = 1'b0;
        tick();
        mcu_wr(4'd0, 32'h10);
        mcu_rd(4'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL timeout_clear: got %h want 0", d);
        end
    endtask

    task automatic test_done_vs_timeout();
        logic [31:0] d;
        cfg_pending = 1'b1;
        tick();
        repeat (15) tick();
        mcu_wr(4'd6, 32'd0);
        checks++;
        if ({cfg_done, cfg_error} !== 2'b10) begin
            errors++;
            $display("FAIL done_wins: got %b want 10",
                     {cfg_done, cfg_error});
        end
        mcu_rd(4'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL done_wins_status: got %h want 0", d);
        end
        cfg_pending = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        logic [31:0] d;
        logic saw;
        cfg_pending = 1'b1;
        tick();
        saw = cfg_done;
        mcu_wr(4'd1, 32'd1);
        saw |= cfg_done;
        tick();
        saw |= cfg_done;
        cfg_pending = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            saw |= cfg_done;
        end
        checks++;
        if (saw !== 1'b0) begin
            errors++;
            $display("FAIL abort_done: got %b want 0", saw);
        end
        mcu_rd(4'd0, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL abort_status: got %h want 0", d);
        end
        mcu_wr(4'd6, 32'd1);
        checks++;
        if (cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_done_write: got %b want 0", cfg_done);
        end
    endtask

    task automatic test_aux_overrun();
        logic [31:0] d;
        aux_rdata = 32'h11;
        aux_pending = 1'b1;
        tick();
        aux_pending = 1'b0;
        tick();
        aux_rdata = 32'h22;
        aux_pending = 1'b1;
        tick();
        aux_pending = 1'b0;
        checks++;
        if (mcu_irq !== 1'b1) begin
            errors++;
            $display("FAIL aux_irq_level: got %b want 1", mcu_irq);
        end
        mcu_rd(4'd7, d);
        checks++;
        if (d !== 32'h22) begin
            errors++;
            $display("FAIL aux_in: got %h want 22", d);
        end
        mcu_rd(4'd0, d);
        checks++;
        if (d !== 32'h08) begin
            errors++;
            $display("FAIL overrun_status: got %h want 08", d);
        end
        mcu_wr(4'd0, 32'h08);
        mcu_rd(4'd0, d);
        tick();
        checks++;
        if (d !== 32'd0 || mcu_irq !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %h irq %b want 0 0",
                     d, mcu_irq);
        end
    endtask

    task automatic test_aux_same_cycle();
        logic [31:0] d;
        aux_rdata = 32'h33;
        aux_pending = 1'b1;
        tick();
        aux_rdata = 32'h44;
        mcu_address = 4'd7;
        mcu_read = 1'b1;
        tick();
        aux_pending = 1'b0;
        mcu_read = 1'b0;
        checks++;
        if (mcu_rdata !== 32'h33) begin
            errors++;
            $display("FAIL race_read: got %h want 33", mcu_rdata);
        end
        mcu_rd(4'd0, d);
        checks++;
        if (d !== 32'h04) begin
            errors++;
            $display("FAIL race_status: got %h want 04", d);
        end
        mcu_rd(4'd7, d);
        checks++;
        if (d !== 32'h44) begin
            errors++;
            $display("FAIL race_new_data: got %h want 44", d);
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        mcu_wr(4'd5, 32'h0000_1111);
        mcu_wr(4'd12, 32'hFFFF_FFFF);
        mcu_rd(4'd12, d);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("FAIL unmapped: got %h want 0", d);
        end
        mcu_address = 4'd5;
        mcu_wdata = 32'h2222_0000;
        mcu_write = 1'b1;
        mcu_read = 1'b1;
        tick();
        mcu_write = 1'b0;
        mcu_read = 1'b0;
        checks++;
        if (mcu_rdata !== 32'h0000_1111) begin
            errors++;
            $display("FAIL rw_same: got %h want 00001111", mcu_rdata);
        end
        mcu_rd(4'd5, d);
        checks++;
        if (d !== 32'h2222_0000 || cfg_wdata_1 !== 32'h2222_0000) begin
            errors++;
            $display("FAIL rsp1: got %h/%h want 22220000",
                     d, cfg_wdata_1);
        end
    endtask

    task automatic test_aux_out_reset();
        logic [31:0] d;
        mcu_wr(4'd8, 32'hA5A5_A5A5);
        checks++;
        if (aux_wdata !== 32'hA5A5_A5A5 || aux_irq !== 1'b1) begin
            errors++;
            $display("FAIL aux_out: got %h irq %b want a5a5a5a5 1",
                     aux_wdata, aux_irq);
        end
        tick();
        checks++;
        if (aux_irq !== 1'b0) begin
            errors++;
            $display("FAIL aux_irq_pulse: got %b want 0", aux_irq);
        end
        cfg_cmd = 8'h99;
        cfg_pending = 1'b1;
        tick();
        mcu_wr(4'd1, 32'd1);
        mcu_rd(4'd1, d);
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if (aux_wdata !== 32'd0 || cfg_wdata_0 !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_data: got %h/%h want 0",
                     aux_wdata, cfg_wdata_0);
        end
        checks++;
        if (mcu_rdata !== 32'd0 || cfg_wdata_1 !== 32'd0) begin
            errors++;
            $display("FAIL async_reset_regs: got %h/%h want 0",
                     mcu_rdata, cfg_wdata_1);
        end
        cfg_pending = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        mcu_rd(4'd0, d);
        checks++;
        if (d !== 32'd0 || cfg_done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: got %h done %b want 0 0",
                     d, cfg_done);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        cfg_pending = 1'b0;
        cfg_cmd     = '0;
        cfg_rdata_0 = '0;
        cfg_rdata_1 = '0;
        aux_pending = 1'b0;
        aux_rdata   = '0;
        mcu_address = '0;
        mcu_write   = 1'b0;
        mcu_read    = 1'b0;
        mcu_wdata   = '0;
        repeat (2) tick();
        test_reset();
        reset_n = 1'b1;
        tick();
        test_basic();
        test_held();
        test_timeout();
        test_done_vs_timeout();
        test_abort();
        test_aux_overrun();
        test_aux_same_cycle();
        test_regs();
        test_aux_out_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
